// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: sequencer request, tile memory and VGA adapter signals.
interface sprite_blitter_if #(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 9,
    parameter int SW    = 6,
    parameter int STEPW = 3,
    parameter int AW    = 14
);
    logic             Start;
    logic [XW-1:0]    Xin;
    logic [YW-1:0]    Yin;
    logic [SW-1:0]    Width;
    logic [SW-1:0]    Height;
    logic [STEPW-1:0] AnimStep;
    logic             FlipX;
    logic             FlipY;
    logic             TransEn;
    logic [CW-1:0]    TransColor;
    logic [2:0]       Sprite;
    logic [CW-1:0]    DataIn;
    logic [2:0]       MemSel;
    logic [AW-1:0]    Address;
    logic [XW-1:0]    Xout;
    logic [YW-1:0]    Yout;
    logic [CW-1:0]    Color;
    logic             VGA_Draw;
    logic             Busy;
    logic             Done;

    // Sequencer / memory / VGA side.
    modport master (
        output Start, Xin, Yin, Width, Height, AnimStep, FlipX, FlipY,
               TransEn, TransColor, Sprite, DataIn,
        input  MemSel, Address, Xout, Yout, Color, VGA_Draw, Busy, Done
    );

    // Blitter side.
    modport slave (
        input  Start, Xin, Yin, Width, Height, AnimStep, FlipX, FlipY,
               TransEn, TransColor, Sprite, DataIn,
        output MemSel, Address, Xout, Yout, Color, VGA_Draw, Busy, Done
    );
endinterface

// File: rtl/sprite_blitter.sv
// Copies one animation frame of a sprite from tile memory to the VGA adapter,
// with flips, colour keying and screen-edge clipping.
module sprite_blitter #(
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 9,
    parameter int SW       = 6,
    parameter int STEPW    = 3,
    parameter int AW       = 14,
    parameter int MEM_LAT  = 1,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic Clock,
    input  logic Resetn,
    sprite_blitter_if.slave bus
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PLOT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [SW-1:0] w_q, h_q, xoff_q, yoff_q;
    logic          fx_q, fy_q, te_q;
    logic [CW-1:0] tc_q;
    logic [2:0]    spr_q;
    logic [AW-1:0] base_q;
    logic [LW-1:0] lat_q;

    logic          last_x, last_y, lat_end, visible, key_hit;
    logic [SW-1:0] src_x, src_y;
    logic [XW:0]   x_sum;
    logic [YW:0]   y_sum;

    assign last_x  = (xoff_q == w_q - SW'(1));
    assign last_y  = (yoff_q == h_q - SW'(1));
    assign lat_end = (lat_q == LW'(MEM_LAT - 1));

    // Mirrored source pixel inside the frame.
    assign src_x = fx_q ? (w_q - SW'(1) - xoff_q) : xoff_q;
    assign src_y = fy_q ? (h_q - SW'(1) - yoff_q) : yoff_q;

    // Sums kept one bit wider so pixels past the right/bottom edge never
    // alias onto column/row 0.
    assign x_sum   = (XW+1)'(x_q) + (XW+1)'(xoff_q);
    assign y_sum   = (YW+1)'(y_q) + (YW+1)'(yoff_q);
    assign visible = (x_sum < (XW+1)'(SCREEN_W)) && (y_sum < (YW+1)'(SCREEN_H));
    assign key_hit = te_q && (bus.DataIn == tc_q);

    assign bus.Address = base_q + AW'(src_y) * AW'(w_q) + AW'(src_x);
    assign bus.Xout    = x_sum[XW-1:0];
    assign bus.Yout    = y_sum[YW-1:0];
    assign bus.Color   = bus.DataIn;
    assign bus.MemSel  = spr_q;

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (bus.Start)
                        state_d = (bus.Width == '0 || bus.Height == '0) ? S_DONE : S_WAIT;
            S_WAIT: if (lat_end) state_d = S_PLOT;
            S_PLOT: state_d = (last_x && last_y) ? S_DONE : S_WAIT;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and draw strobe decoded from the state.
    always_comb begin
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        bus.VGA_Draw = 1'b0;
        unique case (state_q)
            S_WAIT: bus.Busy = 1'b1;
            S_PLOT: begin
                bus.Busy     = 1'b1;
                bus.VGA_Draw = visible && !key_hit;
            end
            S_DONE: bus.Done = 1'b1;
            default: ;
        endcase
    end

    // Request latch, frame base, raster counters and memory latency counter.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x_q    <= '0;
            y_q    <= '0;
            w_q    <= '0;
            h_q    <= '0;
            fx_q   <= 1'b0;
            fy_q   <= 1'b0;
            te_q   <= 1'b0;
            tc_q   <= '0;
            spr_q  <= '0;
            base_q <= '0;
            xoff_q <= '0;
            yoff_q <= '0;
            lat_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (bus.Start) begin
                    x_q    <= bus.Xin;
                    y_q    <= bus.Yin;
                    w_q    <= bus.Width;
                    h_q    <= bus.Height;
                    fx_q   <= bus.FlipX;
                    fy_q   <= bus.FlipY;
                    te_q   <= bus.TransEn;
                    tc_q   <= bus.TransColor;
                    spr_q  <= bus.Sprite;
                    base_q <= AW'(bus.AnimStep) * AW'(bus.Width) * AW'(bus.Height);
                    xoff_q <= '0;
                    yoff_q <= '0;
                    lat_q  <= '0;
                end
                S_WAIT: lat_q <= lat_end ? '0 : lat_q + LW'(1);
                S_PLOT: begin
                    if (!last_x) begin
                        xoff_q <= xoff_q + SW'(1);
                    end else if (!last_y) begin
                        xoff_q <= '0;
                        yoff_q <= yoff_q + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench: directed scenarios plus randomized blits compared
// against a per-pixel reference model built from the raster rules.
module tb_sprite_blitter;
    typedef struct packed {
        logic [15:0] cyc;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [8:0]  col;
        logic [13:0] a;
    } draw_t;

    logic Clock, Resetn, start, sel;
    logic [7:0] cx; logic [6:0] cy; logic [5:0] cw, ch; logic [2:0] cstep;
    logic cfx, cfy, cte; logic [8:0] ctc; logic [2:0] csp;
    logic [8:0]  mem [0:16383];
    logic [13:0] p0;
    logic [13:0] p1 [3];

    int checks = 0, errors = 0;
    draw_t obs_q[$], exp_q[$], bad_o, bad_e;
    int obs_done, obs_busy, exp_done, exp_busy, n_mis;
    logic [13:0] obs_a1;

    sprite_blitter_if b0();
    sprite_blitter_if b1();

    sprite_blitter u0 (.Clock(Clock), .Resetn(Resetn), .bus(b0));
    sprite_blitter #(.MEM_LAT(3)) u1 (.Clock(Clock), .Resetn(Resetn), .bus(b1));

    assign b0.Start = start & ~sel;   assign b1.Start = start & sel;
    assign b0.Xin = cx;               assign b1.Xin = cx;
    assign b0.Yin = cy;               assign b1.Yin = cy;
    assign b0.Width = cw;             assign b1.Width = cw;
    assign b0.Height = ch;            assign b1.Height = ch;
    assign b0.AnimStep = cstep;       assign b1.AnimStep = cstep;
    assign b0.FlipX = cfx;            assign b1.FlipX = cfx;
    assign b0.FlipY = cfy;            assign b1.FlipY = cfy;
    assign b0.TransEn = cte;          assign b1.TransEn = cte;
    assign b0.TransColor = ctc;       assign b1.TransColor = ctc;
    assign b0.Sprite = csp;           assign b1.Sprite = csp;
    assign b0.DataIn = mem[p0];       assign b1.DataIn = mem[p1[2]];

    // Tile memory models with 1 and 3 cycles of read latency.
    always @(posedge Clock) begin
        p0    <= b0.Address;
        p1[0] <= b1.Address;
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    logic o_draw, o_busy, o_done; logic [7:0] o_x; logic [6:0] o_y;
    logic [8:0] o_col; logic [13:0] o_addr; logic [2:0] o_msel;
    assign o_draw = sel ? b1.VGA_Draw : b0.VGA_Draw;
    assign o_busy = sel ? b1.Busy     : b0.Busy;
    assign o_done = sel ? b1.Done     : b0.Done;
    assign o_x    = sel ? b1.Xout     : b0.Xout;
    assign o_y    = sel ? b1.Yout     : b0.Yout;
    assign o_col  = sel ? b1.Color    : b0.Color;
    assign o_addr = sel ? b1.Address  : b0.Address;
    assign o_msel = sel ? b1.MemSel   : b0.MemSel;

    always #5 Clock = ~Clock;

    task automatic set_cfg(input int x, y, w, h, st, fx, fy, te, tc, sp);
        cx = 8'(x); cy = 7'(y); cw = 6'(w); ch = 6'(h); cstep = 3'(st);
        cfx = fx[0]; cfy = fy[0]; cte = te[0]; ctc = 9'(tc); csp = 3'(sp);
    endtask

    // Expected visible draws (with the cycle of each, counted from the Start edge).
    task automatic model();
        int L = sel ? 3 : 1;
        int base, idx, sx, sy, a, px, py;
        draw_t d;
        exp_q.delete();
        idx  = 0;
        base = (int'(cstep) * int'(cw) * int'(ch)) % 16384;
        for (int yo = 0; yo < int'(ch); yo++) begin
            for (int xo = 0; xo < int'(cw); xo++) begin
                sx = cfx ? int'(cw) - 1 - xo : xo;
                sy = cfy ? int'(ch) - 1 - yo : yo;
                a  = (base + sy * int'(cw) + sx) % 16384;
                px = int'(cx) + xo;
                py = int'(cy) + yo;
                if (px < 160 && py < 120 && !(cte && mem[a] == ctc)) begin
                    d.cyc = 16'((idx + 1) * (L + 1));
                    d.x = px[7:0]; d.y = py[6:0]; d.col = mem[a]; d.a = a[13:0];
                    exp_q.push_back(d);
                end
                idx++;
            end
        end
        exp_busy = int'(cw) * int'(ch) * (L + 1);
        exp_done = 1 + exp_busy;
    endtask

    // Issue one Start and record every draw until Done (bounded); ends in IDLE.
    task automatic run_blit();
        draw_t d;
        int lo;
        obs_q.delete(); obs_done = -1; obs_busy = 0;
        model();
        start = 1;
        for (int k = 1; k <= 4000; k++) begin
            @(negedge Clock);
            if (k == 1) begin start = 0; obs_a1 = o_addr; end
            if (o_busy) obs_busy++;
            if (o_draw) begin
                d.cyc = 16'(k); d.x = o_x; d.y = o_y; d.col = o_col; d.a = o_addr;
                obs_q.push_back(d);
            end
            if (o_done) begin obs_done = k; break; end
        end
        start = 0;
        @(negedge Clock);
        n_mis = 0; bad_o = '0; bad_e = '0;
        lo = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < lo; i++)
            if (obs_q[i] !== exp_q[i]) begin
                if (n_mis == 0) begin bad_o = obs_q[i]; bad_e = exp_q[i]; end
                n_mis++;
            end
        n_mis += (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                               : exp_q.size() - obs_q.size();
    endtask

    task automatic test_reset();
        Resetn = 0; start = 0; sel = 0;
        set_cfg(33, 44, 5, 5, 3, 1, 1, 1, 7, 6);
        #1;
        checks++; if (b0.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b0.Busy); end
        checks++; if (b0.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", b0.Done); end
        checks++; if (b0.VGA_Draw !== 1'b0) begin errors++; $display("FAIL reset_draw: got %b want 0", b0.VGA_Draw); end
        checks++; if (b0.Address !== 14'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", b0.Address); end
        checks++; if (b0.Xout !== 8'd0 || b0.Yout !== 7'd0) begin errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", b0.Xout, b0.Yout); end
        checks++; if (b0.MemSel !== 3'd0) begin errors++; $display("FAIL reset_memsel: got %0d want 0", b0.MemSel); end
        repeat (2) @(negedge Clock);
        Resetn = 1;
        @(negedge Clock);
        checks++; if (b0.Busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b want 0", b0.Busy); end
    endtask

    task automatic test_basic();
        sel = 0;
        set_cfg(10, 20, 4, 3, 0, 0, 0, 0, 0, 0);
        run_blit();
        checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL basic_count: got %0d want 12", obs_q.size()); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL basic_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
        checks++; if (obs_done !== 25) begin errors++; $display("FAIL basic_done: got %0d want 25", obs_done); end
        checks++; if (obs_busy !== 24) begin errors++; $display("FAIL basic_busy: got %0d want 24", obs_busy); end
        checks++; if (obs_a1 !== 14'd0) begin errors++; $display("FAIL basic_addr1: got %0d want 0", obs_a1); end
    endtask

    task automatic test_flip();
        logic [13:0] fa, la;
        sel = 0;
        set_cfg(10, 20, 4, 3, 2, 1, 0, 0, 0, 0);
        run_blit();
        fa = (obs_q.size() > 0) ? obs_q[0].a : 14'h3fff;
        la = (obs_q.size() > 0) ? obs_q[$].a : 14'h3fff;
        checks++; if (fa !== 14'd27) begin errors++; $display("FAIL flipx_first: got %0d want 27", fa); end
        checks++; if (la !== 14'd32) begin errors++; $display("FAIL flipx_last: got %0d want 32", la); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL flipx_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
        set_cfg(10, 20, 4, 3, 2, 0, 1, 0, 0, 0);
        run_blit();
        fa = (obs_q.size() > 0) ? obs_q[0].a : 14'h3fff;
        checks++; if (fa !== 14'd32) begin errors++; $display("FAIL flipy_first: got %0d want 32", fa); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL flipy_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
    endtask

    task automatic test_transparency();
        int hit;
        sel = 0;
        mem[5] = 9'h12E;
        set_cfg(10, 20, 4, 3, 0, 0, 0, 1, 'h12E, 0);
        run_blit();
        hit = 0;
        foreach (obs_q[i]) if (obs_q[i].x == 8'd11 && obs_q[i].y == 7'd21) hit++;
        checks++; if (obs_q.size() !== 11) begin errors++; $display("FAIL trans_count: got %0d want 11", obs_q.size()); end
        checks++; if (hit !== 0) begin errors++; $display("FAIL trans_keyed: got %0d draws at (11,21) want 0", hit); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL trans_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
        set_cfg(10, 20, 4, 3, 0, 0, 0, 0, 'h12E, 0);
        run_blit();
        checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL trans_off_count: got %0d want 12", obs_q.size()); end
        mem[5] = 9'd5;
    endtask

    task automatic test_clipping();
        int wrap, row;
        sel = 0;
        set_cfg(158, 20, 4, 2, 0, 0, 0, 0, 0, 0);
        run_blit();
        wrap = 0;
        foreach (obs_q[i]) if (obs_q[i].x < 8'd2) wrap++;
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL clipx_count: got %0d want 4", obs_q.size()); end
        checks++; if (wrap !== 0) begin errors++; $display("FAIL clipx_wrap: got %0d draws at x<2 want 0", wrap); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL clipx_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
        checks++; if (obs_busy !== 16) begin errors++; $display("FAIL clipx_busy: got %0d want 16", obs_busy); end
        set_cfg(10, 119, 4, 3, 0, 0, 0, 0, 0, 0);
        run_blit();
        row = 0;
        foreach (obs_q[i]) if (obs_q[i].y != 7'd119) row++;
        checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL clipy_count: got %0d want 4", obs_q.size()); end
        checks++; if (row !== 0) begin errors++; $display("FAIL clipy_row: got %0d draws off row 119 want 0", row); end
        checks++; if (obs_busy !== 24) begin errors++; $display("FAIL clipy_busy: got %0d want 24", obs_busy); end
    endtask

    task automatic test_zero();
        sel = 0;
        set_cfg(10, 20, 0, 3, 1, 0, 0, 0, 0, 0);
        run_blit();
        checks++; if (obs_done !== 1) begin errors++; $display("FAIL zero_w_done: got %0d want 1", obs_done); end
        checks++; if (obs_q.size() !== 0 || obs_busy !== 0) begin errors++; $display("FAIL zero_w_draws: got %0d draws %0d busy want 0", obs_q.size(), obs_busy); end
        set_cfg(10, 20, 4, 0, 1, 0, 0, 0, 0, 0);
        run_blit();
        checks++; if (obs_done !== 1) begin errors++; $display("FAIL zero_h_done: got %0d want 1", obs_done); end
    endtask

    task automatic test_start_held();
        int d0, d1;
        sel = 0; d0 = -1; d1 = -1;
        set_cfg(10, 20, 2, 1, 0, 0, 0, 0, 0, 0);
        start = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clock);
            if (o_done) begin if (d0 < 0) d0 = k; else if (d1 < 0) d1 = k; end
        end
        start = 0;
        @(negedge Clock);
        checks++; if (d0 !== 5) begin errors++; $display("FAIL held_done1: got %0d want 5", d0); end
        checks++; if (d1 !== 11) begin errors++; $display("FAIL held_done2: got %0d want 11", d1); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL held_stop: busy %b want 0", o_busy); end
        @(negedge Clock);
    endtask

    task automatic test_memlat3();
        sel = 1;
        set_cfg(10, 20, 3, 2, 1, 1, 0, 0, 0, 3);
        run_blit();
        checks++; if (obs_q.size() !== 6) begin errors++; $display("FAIL lat3_count: got %0d want 6", obs_q.size()); end
        checks++; if (n_mis !== 0) begin errors++; $display("FAIL lat3_draws: %0d bad, got %h want %h", n_mis, bad_o, bad_e); end
        checks++; if (obs_done !== 25) begin errors++; $display("FAIL lat3_done: got %0d want 25", obs_done); end
        checks++; if (o_msel !== 3'd3) begin errors++; $display("FAIL lat3_memsel: got %0d want 3", o_msel); end
        sel = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16384; i++) mem[i] = 9'($urandom);
        for (int it = 0; it < 10; it++) begin
            sel = 1'($urandom);
            set_cfg($urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 6),
                    $urandom_range(0, 5), $urandom_range(0, 7), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 7));
            ctc = ($urandom_range(0, 1) == 1) ? mem[$urandom_range(0, 63)] : 9'($urandom);
            if (it < 3) begin cx = 8'($urandom_range(0, 100)); cy = 7'($urandom_range(0, 80)); end
            run_blit();
            checks++; if (n_mis !== 0) begin errors++; $display("FAIL rand%0d_draws: %0d bad, got %h want %h", it, n_mis, bad_o, bad_e); end
            checks++; if (obs_done !== exp_done) begin errors++; $display("FAIL rand%0d_done: got %0d want %0d", it, obs_done, exp_done); end
            checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rand%0d_busy: got %0d want %0d", it, obs_busy, exp_busy); end
            checks++; if (o_msel !== csp) begin errors++; $display("FAIL rand%0d_memsel: got %0d want %0d", it, o_msel, csp); end
        end
        for (int i = 0; i < 16384; i++) mem[i] = 9'(i);
        sel = 0;
    endtask

    task automatic test_reset_mid();
        int cnt, late_d, late_b;
        sel = 0; cnt = 0;
        set_cfg(10, 20, 4, 3, 0, 0, 0, 0, 0, 5);
        start = 1;
        for (int k = 1; k <= 100 && cnt < 5; k++) begin
            @(negedge Clock);
            if (k == 1) start = 0;
            if (o_draw) cnt++;
        end
        checks++; if (cnt !== 5) begin errors++; $display("FAIL rstmid_reach: got %0d draws want 5", cnt); end
        Resetn = 0;
        #1;
        checks++; if ({b0.VGA_Draw, b0.Busy, b0.Done} !== 3'b000) begin errors++; $display("FAIL rstmid_ctrl: got %b want 000", {b0.VGA_Draw, b0.Busy, b0.Done}); end
        checks++; if (b0.Address !== 14'd0 || b0.MemSel !== 3'd0) begin errors++; $display("FAIL rstmid_addr: got %0d/%0d want 0/0", b0.Address, b0.MemSel); end
        checks++; if (b0.Xout !== 8'd0 || b0.Yout !== 7'd0) begin errors++; $display("FAIL rstmid_xy: got %0d,%0d want 0,0", b0.Xout, b0.Yout); end
        repeat (2) @(negedge Clock);
        Resetn = 1;
        late_d = 0; late_b = 0;
        repeat (10) begin
            @(negedge Clock);
            if (b0.VGA_Draw) late_d++;
            if (b0.Busy) late_b++;
        end
        checks++; if (late_d !== 0 || late_b !== 0) begin errors++; $display("FAIL rstmid_after: got %0d draws %0d busy want 0", late_d, late_b); end
        set_cfg(10, 20, 4, 3, 0, 0, 0, 0, 0, 0);
        run_blit();
        checks++; if (obs_done !== 25 || n_mis !== 0) begin errors++; $display("FAIL rstmid_recover: done %0d bad %0d want 25/0", obs_done, n_mis); end
    endtask

    initial begin
        Clock = 0; Resetn = 0; start = 0; sel = 0;
        for (int i = 0; i < 16384; i++) mem[i] = 9'(i);
        test_reset();
        test_basic();
        test_flip();
        test_transparency();
        test_clipping();
        test_zero();
        test_start_held();
        test_memlat3();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised successor to the sprite drawer: copies one animation frame of a rectangular sprite from tile memory to the VGA adapter pixel by pixel. Adds the following over the fixed-size drawer:
- configurable coordinate, colour and address widths;
- configurable memory read latency;
- horizontal and vertical flip;
- a programmable transparency colour with enable;
- clipping against the screen edge;
- a single-cycle Start/Busy/Done handshake.

It sits between the game-object sequencer and the VGA adapter, driving the memory address and MemSel-style select lines.

## Interface
- XW, 8: screen X width (bits).
- YW, 7: screen Y width (bits).
- CW, 9: colour width.
- SW, 6: sprite dimension width; maximum sprite is 2^SW-1 pixels per side.
- STEPW, 3: animation step width.
- AW, 14: tile memory address width.
- MEM_LAT, 1: tile memory read latency in cycles, from Address change to valid DataIn; must be at least 1.
- SCREEN_W, 160: visible columns.
- SCREEN_H, 120: visible rows.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  reset; one clock; reset is asynchronous and active-low.
- Start  in  1  request a blit; sampled only in IDLE.
- Xin  in  XW  sprite top-left X.
- Yin  in  YW  sprite top-left Y.
- Width, Height  in  SW  sprite size in pixels.
- AnimStep  in  STEPW  frame index.
- FlipX, FlipY  in  1  mirror horizontally / vertically.
- TransEn  in  1  enable transparency keying.
- TransColor  in  CW  transparent colour.
- Sprite  in  3  memory select; passed through to MemSel.
- DataIn  in  CW  pixel colour from tile memory.
- MemSel  out  3  = latched Sprite.
- Address  out  AW  tile memory address.
- Xout  out  XW  VGA X.
- Yout  out  YW  VGA Y.
- Color  out  CW  VGA colour (= DataIn).
- VGA_Draw  out  1  VGA write strobe.
- Busy  out  1  blit in progress.
- Done  out  1  one-cycle completion pulse.

## Operation
- **Latching.** On Start in IDLE, the block latches Xin, Yin, Width, Height, AnimStep, FlipX, FlipY, TransEn, TransColor and Sprite. Input changes during a blit have no effect.
- **Frame base.** Base = AnimStep*Width*Height is computed once into a register at Start, truncated mod 2^AW.
- **Counters.** xoff in 0..Width-1 (inner loop) and yoff in 0..Height-1 (outer loop), raster order, both cleared at Start.
- **Source coordinates.**
  - srcX = FlipX ? Width-1-xoff : xoff.
  - srcY = FlipY ? Height-1-yoff : yoff.
  - Address = Base + srcY*Width + srcX, mod 2^AW; combinational from registers.
- **Screen coordinates.** Xout = Xlatched + xoff and Yout = Ylatched + yoff, each truncated to XW/YW.
- **Clipping.** The on-screen test uses the full XW+1 / YW+1 bit sums: a pixel is visible iff the sum is < SCREEN_W (resp. SCREEN_H). Off-screen pixels still step the counters but are never drawn; they must never wrap to column or row 0.
- **VGA_Draw** = (state==PLOT) & visible & ~(TransEn & DataIn==TransColor).
- **FSM states:**
  - IDLE: Busy=0. Start → WAIT; if Width==0 or Height==0 → DONE with no draws.
  - WAIT: Busy=1; waits MEM_LAT cycles with a latency counter, then → PLOT.
  - PLOT: Busy=1; one cycle.
    - If xoff<Width-1: xoff++, → WAIT.
    - Else if yoff<Height-1: xoff=0, yoff++, → WAIT.
    - Else → DONE.
  - DONE: Done=1, Busy=0, one cycle; → IDLE. Start is ignored in DONE.
- **Reset values.** Every register is 0; state IDLE; Busy=0, Done=0, VGA_Draw=0, Address=0, Xout=0, Yout=0, MemSel=0. Color follows DataIn.
- **Reset mid-blit.** Asynchronous reset aborts the blit immediately: VGA_Draw, Busy and Done all drop and there is no further draw.

## Timing
- Start high at edge N (IDLE) → Busy=1 from N+1, with the first Address valid at N+1.
- Each pixel takes MEM_LAT+1 cycles: MEM_LAT WAIT cycles plus 1 PLOT cycle.
- Done is high in exactly cycle N+1+W*H*(MEM_LAT+1); the next accepted Start is one cycle later.
- Zero-size sprite: Done is high at N+1.
- VGA_Draw and Xout/Yout/Color are valid together in the PLOT cycle only. Between PLOT cycles, Xout/Yout hold the current counter values and VGA_Draw=0.

## Test plan
- **Basic raster.** MEM_LAT=1, W=4, H=3, (10,20), AnimStep=0, memory = address. Required: 12 VGA_Draw pulses, every 2nd cycle; Address 0..11; (Xout,Yout) = (10,20)…(13,22); Color = Address; Done at cycle 25 after Start.
- **Frame base and flips.** AnimStep=2, W=4, H=3.
  - FlipX: first pixel Address 27 at (10,20); last pixel Address 32.
  - FlipY: first pixel Address 32.
- **Transparency.** TransEn=1, TransColor=9'h12E, with memory word 5 = 9'h12E. Required: 11 draws, none at (11,21). With TransEn=0: 12 draws.
- **Clipping.** Xin=158, W=4, H=2; then Yin=119, H=3. Required: only x∈{158,159} drawn, with no draw at x=0/1; only row 119 drawn. Busy still lasts the full W*H*(MEM_LAT+1) cycles.
- **Handshake edges.**
  - W=0: Done at N+1, no draws.
  - Start held continuously: a new blit begins one cycle after each Done.
  - MEM_LAT=3: 4 cycles per pixel.
- **Reset mid-blit.** Drop Resetn after the 5th draw. Required: all outputs 0 immediately; after release, IDLE and no draws until the next Start.
